// File: rtl/seq_10101_gen_if.sv
// Serial pattern transmitter bus: request fields in, serial bit stream and status out.
// err_inj exists only when SEQ_GEN_ERR_INJ_EN is defined.
interface seq_10101_gen_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic [GAP_W-1:0] gap;
`ifdef SEQ_GEN_ERR_INJ_EN
   logic             err_inj;
`endif
   logic             out;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      input  start, count, gap,
`ifdef SEQ_GEN_ERR_INJ_EN
      input  err_inj,
`endif
      output out, valid, busy, done
   );

   modport slave (
      output start, count, gap,
`ifdef SEQ_GEN_ERR_INJ_EN
      output err_inj,
`endif
      input  out, valid, busy, done
   );
endinterface

// File: rtl/seq_10101_gen.sv
// Emits count frames of PATTERN (MSB first) separated by gap zero bits; registered Moore outputs.
// SEQ_GEN_ERR_INJ_EN adds err_inj, which inverts the last bit of the first frame.
module seq_10101_gen #(
   parameter logic [4:0] PATTERN = 5'b10101,
   parameter int         CNT_W   = 8,
   parameter int         GAP_W   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_10101_gen_if.master       bus
);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   localparam logic [CNT_W-1:0] FRM_ONE = CNT_W'(1);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   state_t           state, state_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [CNT_W-1:0] frm, frm_nxt;
   logic [GAP_W-1:0] gap_q, gap_nxt;
   logic [GAP_W-1:0] gcnt, gcnt_nxt;
   logic             out_nxt, valid_nxt, busy_nxt, done_nxt;
   logic             bit_nxt;
`ifdef SEQ_GEN_ERR_INJ_EN
   // Set on an injected start, cleared once the first frame has been sent
   logic             inj_q, inj_nxt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         frm       <= '0;
         gap_q     <= '0;
         gcnt      <= '0;
         bus.out   <= 1'b0;
         bus.valid <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
`ifdef SEQ_GEN_ERR_INJ_EN
         inj_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         frm       <= frm_nxt;
         gap_q     <= gap_nxt;
         gcnt      <= gcnt_nxt;
         bus.out   <= out_nxt;
         bus.valid <= valid_nxt;
         bus.busy  <= busy_nxt;
         bus.done  <= done_nxt;
`ifdef SEQ_GEN_ERR_INJ_EN
         inj_q     <= inj_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      frm_nxt   = frm;
      gap_nxt   = gap_q;
      gcnt_nxt  = gcnt;
`ifdef SEQ_GEN_ERR_INJ_EN
      inj_nxt   = inj_q;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.count != '0) begin
                  state_nxt = SEND;
                  frm_nxt   = bus.count;
                  gap_nxt   = bus.gap;
                  idx_nxt   = 3'd4;
`ifdef SEQ_GEN_ERR_INJ_EN
                  inj_nxt   = bus.err_inj;
`endif
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         SEND: begin
            if (idx != 3'd0) begin
               idx_nxt = idx - 3'd1;
            end else begin
`ifdef SEQ_GEN_ERR_INJ_EN
               inj_nxt = 1'b0;
`endif
               // frm counts frames still owed including the one just finished
               if (frm > FRM_ONE) begin
                  frm_nxt = frm - FRM_ONE;
                  if (gap_q != '0) begin
                     state_nxt = GAP;
                     gcnt_nxt  = gap_q;
                  end else begin
                     idx_nxt = 3'd4;
                  end
               end else begin
                  frm_nxt   = '0;
                  state_nxt = DONE;
               end
            end
         end
         GAP: begin
            if (gcnt <= GAP_ONE) begin
               gcnt_nxt  = '0;
               idx_nxt   = 3'd4;
               state_nxt = SEND;
            end else begin
               gcnt_nxt = gcnt - GAP_ONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so they land in registers
      bit_nxt = PATTERN[idx_nxt];
`ifdef SEQ_GEN_ERR_INJ_EN
      if (inj_nxt && (idx_nxt == 3'd0)) begin
         bit_nxt = ~bit_nxt;
      end
`endif
      out_nxt   = (state_nxt == SEND) ? bit_nxt : 1'b0;
      valid_nxt = (state_nxt == SEND) || (state_nxt == GAP);
      busy_nxt  = valid_nxt;
      done_nxt  = (state_nxt == DONE);
   end
endmodule

// File: tb/tb_seq_10101_gen.sv
// Directed bench for seq_10101_gen: captures output streams and compares against hand-built vectors.
module tb_seq_10101_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] c_out, c_vld, c_busy, c_done;

   always #5 clk = ~clk;

   seq_10101_gen_if #(.CNT_W(8), .GAP_W(4)) bus();

   seq_10101_gen #(.PATTERN(5'b10101), .CNT_W(8), .GAP_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Non-overlapping 10101 detector over the valid bits of a capture, oldest bit at n-1
   function automatic int detect(input logic [31:0] o, input logic [31:0] v, input int n);
      logic [4:0] sh;
      int hits;
      sh = '0;
      hits = 0;
      for (int i = n - 1; i >= 0; i--) begin
         if (v[i]) begin
            sh = {sh[3:0], o[i]};
            if (sh == 5'b10101) begin
               hits++;
               sh = '0;
            end
         end
      end
      return hits;
   endfunction

   task automatic launch(input logic [7:0] cnt, input logic [3:0] g);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.count = cnt;
      bus.gap   = g;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Samples n cycles at negedge; optionally pulses start (with new count/gap) after sample pulse_at
   task automatic capture(input int n, input int pulse_at);
      c_out = '0; c_vld = '0; c_busy = '0; c_done = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         c_out  = {c_out[30:0], bus.out};
         c_vld  = {c_vld[30:0], bus.valid};
         c_busy = {c_busy[30:0], bus.busy};
         c_done = {c_done[30:0], bus.done};
         if (k == pulse_at) begin
            bus.start = 1'b1;
            bus.count = 8'd5;
            bus.gap   = 4'd3;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b1;
      bus.count = 8'd1;
      bus.gap   = 4'd0;
      repeat (2) @(negedge clk);
      checks++; if (bus.out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", bus.out); end
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      reset = 1'b0;
      bus.start = 1'b0;
      capture(3, 0);
      checks++; if (c_vld[2:0] !== 3'b000) begin errors++; $display("FAIL reset_idle_valid got %b want 000", c_vld[2:0]); end
   endtask

   task automatic test_single;
      launch(8'd1, 4'd0);
      capture(8, 0);
      checks++; if (c_out[7:0] !== 8'b10101_000) begin errors++; $display("FAIL single_out got %b want 10101000", c_out[7:0]); end
      checks++; if (c_vld[7:0] !== 8'b11111_000) begin errors++; $display("FAIL single_valid got %b want 11111000", c_vld[7:0]); end
      checks++; if (c_busy[7:0] !== 8'b11111_000) begin errors++; $display("FAIL single_busy got %b want 11111000", c_busy[7:0]); end
      checks++; if (c_done[7:0] !== 8'b00000_100) begin errors++; $display("FAIL single_done got %b want 00000100", c_done[7:0]); end
      checks++; if (detect(c_out, c_vld, 8) !== 1) begin errors++; $display("FAIL single_detect got %0d want 1", detect(c_out, c_vld, 8)); end
   endtask

   task automatic test_back_to_back;
      launch(8'd2, 4'd0);
      capture(12, 0);
      checks++; if (c_out[11:0] !== 12'b10101_10101_00) begin errors++; $display("FAIL b2b_out got %b want 101011010100", c_out[11:0]); end
      checks++; if (c_vld[11:0] !== 12'b1111111111_00) begin errors++; $display("FAIL b2b_valid got %b want 111111111100", c_vld[11:0]); end
      checks++; if (c_done[11:0] !== 12'b0000000000_10) begin errors++; $display("FAIL b2b_done got %b want 000000000010", c_done[11:0]); end
      checks++; if (detect(c_out, c_vld, 12) !== 2) begin errors++; $display("FAIL b2b_detect got %0d want 2", detect(c_out, c_vld, 12)); end
   endtask

   task automatic test_gap;
      launch(8'd3, 4'd2);
      capture(22, 0);
      checks++; if (c_out[21:0] !== 22'b10101_00_10101_00_10101_000) begin errors++; $display("FAIL gap_out got %b want 1010100101010010101000", c_out[21:0]); end
      checks++; if (c_vld[21:0] !== 22'b1111111111111111111_000) begin errors++; $display("FAIL gap_valid got %b want 1111111111111111111000", c_vld[21:0]); end
      checks++; if (c_busy[21:0] !== 22'b1111111111111111111_000) begin errors++; $display("FAIL gap_busy got %b want 1111111111111111111000", c_busy[21:0]); end
      checks++; if (c_done[21:0] !== 22'b0000000000000000000_100) begin errors++; $display("FAIL gap_done got %b want 0000000000000000000100", c_done[21:0]); end
      checks++; if (detect(c_out, c_vld, 22) !== 3) begin errors++; $display("FAIL gap_detect got %0d want 3", detect(c_out, c_vld, 22)); end
   endtask

   task automatic test_gap_max;
      launch(8'd2, 4'd15);
      capture(28, 0);
      checks++; if (c_out[27:0] !== 28'b10101_000000000000000_10101_000) begin errors++; $display("FAIL gapmax_out got %b want 1010100000000000000010101000", c_out[27:0]); end
      checks++; if (c_vld[27:0] !== 28'b1111111111111111111111111_000) begin errors++; $display("FAIL gapmax_valid got %b want 1111111111111111111111111000", c_vld[27:0]); end
      checks++; if (c_done[27:0] !== 28'b0000000000000000000000000_100) begin errors++; $display("FAIL gapmax_done got %b want 0000000000000000000000000100", c_done[27:0]); end
   endtask

   task automatic test_zero_count;
      launch(8'd0, 4'd3);
      capture(4, 0);
      checks++; if (c_done[3:0] !== 4'b1000) begin errors++; $display("FAIL zero_done got %b want 1000", c_done[3:0]); end
      checks++; if (c_vld[3:0] !== 4'b0000) begin errors++; $display("FAIL zero_valid got %b want 0000", c_vld[3:0]); end
      checks++; if (c_busy[3:0] !== 4'b0000) begin errors++; $display("FAIL zero_busy got %b want 0000", c_busy[3:0]); end
      checks++; if (c_out[3:0] !== 4'b0000) begin errors++; $display("FAIL zero_out got %b want 0000", c_out[3:0]); end
   endtask

   task automatic test_ignore_start;
      launch(8'd1, 4'd0);
      capture(11, 2);
      checks++; if (c_out[10:0] !== 11'b10101_000000) begin errors++; $display("FAIL ignore_out got %b want 10101000000", c_out[10:0]); end
      checks++; if (c_vld[10:0] !== 11'b11111_000000) begin errors++; $display("FAIL ignore_valid got %b want 11111000000", c_vld[10:0]); end
      checks++; if (c_done[10:0] !== 11'b00000_100000) begin errors++; $display("FAIL ignore_done got %b want 00000100000", c_done[10:0]); end
   endtask

   task automatic test_reset_mid;
      launch(8'd1, 4'd0);
      capture(2, 0);
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({bus.out, bus.valid, bus.busy, bus.done} !== 4'b0000) begin errors++; $display("FAIL midreset_async got %b want 0000", {bus.out, bus.valid, bus.busy, bus.done}); end
      @(negedge clk);
      reset = 1'b0;
      capture(8, 0);
      checks++; if (c_done[7:0] !== 8'h00) begin errors++; $display("FAIL midreset_done got %b want 00000000", c_done[7:0]); end
      checks++; if (c_vld[7:0] !== 8'h00) begin errors++; $display("FAIL midreset_valid got %b want 00000000", c_vld[7:0]); end
      checks++; if (c_out[7:0] !== 8'h00) begin errors++; $display("FAIL midreset_out got %b want 00000000", c_out[7:0]); end
   endtask

`ifdef SEQ_GEN_ERR_INJ_EN
   task automatic test_err_inj;
      bus.err_inj = 1'b1;
      launch(8'd2, 4'd1);
      bus.err_inj = 1'b0;
      capture(14, 0);
      checks++; if (c_out[13:0] !== 14'b10100_0_10101_000) begin errors++; $display("FAIL errinj_out got %b want 10100010101000", c_out[13:0]); end
      checks++; if (c_vld[13:0] !== 14'b11111111111_000) begin errors++; $display("FAIL errinj_valid got %b want 11111111111000", c_vld[13:0]); end
      checks++; if (c_done[13:0] !== 14'b00000000000_100) begin errors++; $display("FAIL errinj_done got %b want 00000000000100", c_done[13:0]); end
      checks++; if (detect(c_out, c_vld, 14) !== 1) begin errors++; $display("FAIL errinj_detect got %0d want 1", detect(c_out, c_vld, 14)); end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      bus.count = '0;
      bus.gap   = '0;
`ifdef SEQ_GEN_ERR_INJ_EN
      bus.err_inj = 1'b0;
`endif
      test_reset;
      test_single;
      test_back_to_back;
      test_gap;
      test_gap_max;
      test_zero_count;
      test_ignore_start;
      test_reset_mid;
`ifdef SEQ_GEN_ERR_INJ_EN
      test_err_inj;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
